pid_chan_scheduler: RTL and testbench

PID_CHAN_SCHEDULER -- requirements
Module: pid_chan_scheduler

---
 rtl/pid_chan_scheduler_if.sv | 22 ++
 rtl/pid_chan_scheduler.sv | 161 ++++++++++++++++
 tb/tb_pid_chan_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_chan_scheduler_if.sv
// Sample-in / issue-out bus between the channel sources, the scheduler and the PID filter.
interface pid_chan_scheduler_if #(
    parameter int unsigned N_CHAN = 20,
    parameter int unsigned W_CHAN = 5,
    parameter int unsigned W_DIN  = 27
);
    logic [N_CHAN-1:0]       smp_valid_in;
    logic [N_CHAN*W_DIN-1:0] smp_data_in;
    logic                    dv_out;
    logic [W_CHAN-1:0]       chan_out;
    logic [W_DIN-1:0]        data_out;

    modport master (
        output smp_valid_in, smp_data_in,
        input  dv_out, chan_out, data_out
    );

    modport slave (
        input  smp_valid_in, smp_data_in,
        output dv_out, chan_out, data_out
    );
endinterface

// File: rtl/pid_chan_scheduler.sv
// Round-robin scheduler feeding per-channel samples into a shared PID filter.
// Optional per-channel reissue lockout enabled by macro PID_SCHED_HAZARD_EN.
module pid_chan_scheduler #(
    parameter int unsigned W_CHAN     = 5,
    parameter int unsigned N_CHAN     = 20,
    parameter int unsigned W_DIN      = 27,
    parameter int unsigned HAZARD_GAP = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     run_in,
    pid_chan_scheduler_if.slave      smp_if,
    input  logic                     ovf_clr_in,
    output logic [N_CHAN-1:0]        ovf_out,
    output logic [1:0]               state_out,
    output logic                     busy_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_CHAN-1:0]   pend_q, pend_d;
    logic [N_CHAN-1:0]   ovf_d;
    logic [N_CHAN-1:0]   lock_free;
    logic [N_CHAN-1:0]   elig;
    logic [N_CHAN-1:0]   grant_mask;
    logic                grant_vld;
    logic [W_CHAN-1:0]   grant_idx;
    logic [W_CHAN-1:0]   last_q;
    logic [W_DIN-1:0]    samp_q [N_CHAN];
    logic                active;

    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign elig      = pend_q & lock_free & {N_CHAN{active}};
    assign state_out = state_q;

`ifdef PID_SCHED_HAZARD_EN
    localparam int unsigned W_LOCK = (HAZARD_GAP > 2) ? $clog2(HAZARD_GAP) : 1;

    logic [W_LOCK-1:0] lock_q [N_CHAN];

    always_comb begin
        lock_free = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            lock_free[i] = (lock_q[i] == '0);
        end
    end

    // Granted channel is blocked for HAZARD_GAP-1 cycles after its grant cycle.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (!rst_n_in) begin
                lock_q[i] <= '0;
            end else if (grant_mask[i]) begin
                lock_q[i] <= W_LOCK'(HAZARD_GAP - 1);
            end else if (lock_q[i] != '0) begin
                lock_q[i] <= lock_q[i] - W_LOCK'(1);
            end
        end
    end
`else
    assign lock_free = '1;
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin : p_arb
        int unsigned idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
        for (int unsigned k = 1; k <= N_CHAN; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_CHAN) begin
                idx = idx - N_CHAN;
            end
            if (!grant_vld && elig[idx]) begin
                grant_vld       = 1'b1;
                grant_idx       = W_CHAN'(idx);
                grant_mask[idx] = 1'b1;
            end
        end
    end

    // A strobe landing on a still-pending, ungranted channel is an overrun.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_out & ~{N_CHAN{ovf_clr_in}};
        for (int i = 0; i < N_CHAN; i++) begin
            if (grant_mask[i]) begin
                pend_d[i] = 1'b0;
            end
            if (smp_if.smp_valid_in[i]) begin
                if (pend_q[i] && !grant_mask[i]) begin
                    ovf_d[i] = 1'b1;
                end
                pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run_in) state_d = S_RUN;
            S_RUN:   if (!run_in) state_d = S_DRAIN;
            S_DRAIN: begin
                if (run_in) begin
                    state_d = S_RUN;
                end else if (pend_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pend_q          <= '0;
            ovf_out         <= '0;
            busy_out        <= 1'b0;
            last_q          <= W_CHAN'(N_CHAN - 1);
            smp_if.dv_out   <= 1'b0;
            smp_if.chan_out <= '0;
            smp_if.data_out <= '0;
        end else begin
            pend_q        <= pend_d;
            ovf_out       <= ovf_d;
            busy_out      <= |pend_d;
            smp_if.dv_out <= grant_vld;
            if (grant_vld) begin
                last_q          <= grant_idx;
                smp_if.chan_out <= grant_idx;
                smp_if.data_out <= samp_q[grant_idx];
            end
        end
    end

    // Sample holding registers; contents are meaningless unless pending.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (smp_if.smp_valid_in[i]) begin
                samp_q[i] <= smp_if.smp_data_in[i*W_DIN +: W_DIN];
            end
        end
    end

endmodule

// File: tb/tb_pid_chan_scheduler.sv
// Bench for pid_chan_scheduler: directed table, corner sequences and a random run against a reference model.
module tb_pid_chan_scheduler;

    localparam int unsigned W_CHAN     = 5;
    localparam int unsigned N_CHAN     = 20;
    localparam int unsigned W_DIN      = 27;
    localparam int unsigned HAZARD_GAP = 6;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              run_in;
    logic              ovf_clr_in;
    logic [N_CHAN-1:0] ovf_out;
    logic [1:0]        state_out;
    logic              busy_out;

    pid_chan_scheduler_if #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DIN(W_DIN)) smp_if ();

    pid_chan_scheduler #(
        .W_CHAN(W_CHAN), .N_CHAN(N_CHAN), .W_DIN(W_DIN), .HAZARD_GAP(HAZARD_GAP)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .run_in(run_in),
        .smp_if(smp_if),
        .ovf_clr_in(ovf_clr_in),
        .ovf_out(ovf_out),
        .state_out(state_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: pending set, held samples, lockouts and round-robin pointer.
    bit               m_pend [N_CHAN];
    logic [W_DIN-1:0] m_samp [N_CHAN];
    int               m_lock [N_CHAN];
    bit               m_ovf  [N_CHAN];
    int               m_last;
    int               m_state;
    bit               m_dv;
    bit               m_busy;
    int               m_chan;
    logic [W_DIN-1:0] m_data;

    function automatic void model_step(input bit rst, input bit run, input logic [N_CHAN-1:0] v,
                                       input logic [N_CHAN*W_DIN-1:0] d, input bit clr);
        int g;
        int c;
        bit any;
        if (!rst) begin
            for (int i = 0; i < N_CHAN; i++) begin
                m_pend[i] = 1'b0;
                m_lock[i] = 0;
                m_ovf[i]  = 1'b0;
            end
            m_last  = N_CHAN - 1;
            m_state = 0;
            m_dv    = 1'b0;
            m_chan  = 0;
            m_data  = '0;
            m_busy  = 1'b0;
            return;
        end
        g = -1;
        if (m_state != 0) begin
            for (int k = 1; k <= N_CHAN; k++) begin
                c = (m_last + k) % N_CHAN;
                if (m_pend[c] && m_lock[c] == 0) begin
                    g = c;
                    break;
                end
            end
        end
        m_dv = (g >= 0);
        if (g >= 0) begin
            m_chan    = g;
            m_data    = m_samp[g];
            m_pend[g] = 1'b0;
            m_last    = g;
        end
`ifdef PID_SCHED_HAZARD_EN
        for (int i = 0; i < N_CHAN; i++) begin
            if (i == g) m_lock[i] = int'(HAZARD_GAP) - 1;
            else if (m_lock[i] > 0) m_lock[i] = m_lock[i] - 1;
        end
`endif
        if (clr) begin
            for (int i = 0; i < N_CHAN; i++) m_ovf[i] = 1'b0;
        end
        for (int i = 0; i < N_CHAN; i++) begin
            if (v[i]) begin
                if (m_pend[i]) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_samp[i] = d[i*W_DIN +: W_DIN];
            end
        end
        any = 1'b0;
        for (int i = 0; i < N_CHAN; i++) any = any | m_pend[i];
        case (m_state)
            0: if (run) m_state = 1;
            1: if (!run) m_state = 2;
            default: begin
                if (run) m_state = 1;
                else if (!any) m_state = 0;
            end
        endcase
        m_busy = any;
    endfunction

    function automatic logic [N_CHAN*W_DIN-1:0] ramp(input int base);
        logic [N_CHAN*W_DIN-1:0] r;
        r = '0;
        for (int i = 0; i < N_CHAN; i++) r[i*W_DIN +: W_DIN] = W_DIN'(base + i);
        return r;
    endfunction

    task automatic compare_model();
        logic [N_CHAN-1:0] e_ovf;
        for (int i = 0; i < N_CHAN; i++) e_ovf[i] = m_ovf[i];
        check("model_dv", longint'(smp_if.dv_out), longint'(m_dv));
        check("model_chan", longint'(smp_if.chan_out), longint'(m_chan));
        check("model_data", longint'(smp_if.data_out), longint'(m_data));
        check("model_state", longint'(state_out), longint'(m_state));
        check("model_busy", longint'(busy_out), longint'(m_busy));
        check("model_ovf", longint'(ovf_out), longint'(e_ovf));
    endtask

    task automatic cycle(input bit rst, input bit run, input logic [N_CHAN-1:0] v,
                         input logic [N_CHAN*W_DIN-1:0] d, input bit clr);
        rst_n_in            = rst;
        run_in              = run;
        smp_if.smp_valid_in = v;
        smp_if.smp_data_in  = d;
        ovf_clr_in          = clr;
        model_step(rst, run, v, d, clr);
        @(posedge clk_in);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit                rst_n;
        bit                run;
        logic [N_CHAN-1:0] valid;
        bit                exp_dv;
        int                exp_chan;
        int                exp_data;
        int                exp_state;
        bit                exp_busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [N_CHAN*W_DIN-1:0] d100;
        logic [N_CHAN*W_DIN-1:0] dr;
        logic [N_CHAN-1:0]       vr;
        int prev;
        int issues;
        int gap_exp;
        int issues_exp;
        bit ovf3_exp;
        bit run_r;

        rst_n_in            = 1'b0;
        run_in              = 1'b0;
        ovf_clr_in          = 1'b0;
        smp_if.smp_valid_in = '0;
        smp_if.smp_data_in  = '0;
        d100                = ramp(100);

        // Directed: last_grant=4 then 5,2 order, wrap 19 -> 0, drain to idle.
        tbl[0]  = '{1'b0, 1'b0, 20'h00000, 1'b0,  0,   0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 20'h00010, 1'b0,  0,   0, 0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 20'h00000, 1'b0,  0,   0, 1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 20'h00000, 1'b1,  4, 104, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 20'h00024, 1'b0,  4, 104, 1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 20'h00000, 1'b1,  5, 105, 1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 20'h00000, 1'b1,  2, 102, 1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 20'h80000, 1'b0,  2, 102, 1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 20'h00001, 1'b1, 19, 119, 1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 20'h00000, 1'b1,  0, 100, 2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 20'h00000, 1'b0,  0, 100, 0, 1'b0};

        for (int r = 0; r < 11; r++) begin
            rst_n_in            = tbl[r].rst_n;
            run_in              = tbl[r].run;
            smp_if.smp_valid_in = tbl[r].valid;
            smp_if.smp_data_in  = d100;
            ovf_clr_in          = 1'b0;
            @(posedge clk_in);
            #1;
            check($sformatf("tbl%0d_dv", r), longint'(smp_if.dv_out), longint'(tbl[r].exp_dv));
            check($sformatf("tbl%0d_chan", r), longint'(smp_if.chan_out), longint'(tbl[r].exp_chan));
            check($sformatf("tbl%0d_data", r), longint'(smp_if.data_out), longint'(tbl[r].exp_data));
            check($sformatf("tbl%0d_state", r), longint'(state_out), longint'(tbl[r].exp_state));
            check($sformatf("tbl%0d_busy", r), longint'(busy_out), longint'(tbl[r].exp_busy));
            check($sformatf("tbl%0d_ovf", r), longint'(ovf_out), 0);
        end

        // All channels strobed once with data_i=i: 20 back-to-back issues in index order.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, '1, ramp(0), 1'b0);
        for (int k = 0; k < N_CHAN; k++) begin
            cycle(1'b1, 1'b1, '0, '0, 1'b0);
            check($sformatf("burst%0d_dv", k), longint'(smp_if.dv_out), 1);
            check($sformatf("burst%0d_chan", k), longint'(smp_if.chan_out), longint'(k));
            check($sformatf("burst%0d_data", k), longint'(smp_if.data_out), longint'(k));
        end
        cycle(1'b1, 1'b1, '0, '0, 1'b0);
        check("burst_end_dv", longint'(smp_if.dv_out), 0);

        // Channel 3 strobed every cycle.
`ifdef PID_SCHED_HAZARD_EN
        gap_exp    = int'(HAZARD_GAP);
        issues_exp = 5;
        ovf3_exp   = 1'b1;
`else
        gap_exp    = 1;
        issues_exp = 30;
        ovf3_exp   = 1'b0;
`endif
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 20'h00008, d100, 1'b0);
        prev   = -1;
        issues = 0;
        for (int j = 1; j <= 30; j++) begin
            cycle(1'b1, 1'b1, 20'h00008, ramp(j), 1'b0);
            if (smp_if.dv_out) begin
                if (prev >= 0) check("ch3_gap", longint'(j - prev), longint'(gap_exp));
                prev = j;
                issues++;
            end
        end
        check("ch3_issues", longint'(issues), longint'(issues_exp));
        check("ch3_ovf", longint'(ovf_out[3]), longint'(ovf3_exp));

        // run_in dropped with four channels pending.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 20'h10842, d100, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        check("drain_state", longint'(state_out), 2);
        issues = int'(smp_if.dv_out);
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, 1'b0, '0, '0, 1'b0);
            issues += int'(smp_if.dv_out);
        end
        check("drain_issues", longint'(issues), 4);
        check("drain_idle", longint'(state_out), 0);
        check("drain_busy", longint'(busy_out), 0);

        // Overrun coincident with clear wins; a lone clear then drops it.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, 20'h00080, d100, 1'b0);
        cycle(1'b1, 1'b0, 20'h00080, d100, 1'b1);
        check("ovf7_set", longint'(ovf_out[7]), 1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        check("ovf7_clr", longint'(ovf_out[7]), 0);

        // Reset with ten channels pending in RUN discards them.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 20'h003FF, d100, 1'b0);
        check("pre_rst_busy", longint'(busy_out), 1);
        cycle(1'b0, 1'b1, '0, '0, 1'b0);
        check("rst_dv", longint'(smp_if.dv_out), 0);
        check("rst_state", longint'(state_out), 0);
        check("rst_busy", longint'(busy_out), 0);
        issues = 0;
        for (int j = 0; j < 8; j++) begin
            cycle(1'b1, 1'b1, '0, '0, 1'b0);
            issues += int'(smp_if.dv_out);
        end
        check("post_rst_issues", longint'(issues), 0);

        // Random traffic against the model.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) run_r = ~run_r;
            vr = N_CHAN'($urandom & $urandom);
            if ($urandom_range(0, 3) != 0) vr = vr & N_CHAN'($urandom);
            for (int i = 0; i < N_CHAN; i++) dr[i*W_DIN +: W_DIN] = W_DIN'($urandom);
            cycle(($urandom_range(0, 249) != 0), run_r, vr, dr, ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
